// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory access stage (master) and the memory (slave).
interface mem_access_stage_if;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic [31:0] dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic [3:0]  dmem_be_out;
  logic        dmem_ack_in;
  logic [31:0] dmem_rdata_in;

  modport master (
    output dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_be_out,
    input  dmem_ack_in, dmem_rdata_in
  );

  modport slave (
    input  dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_be_out,
    output dmem_ack_in, dmem_rdata_in
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory access stage: one dmem bus transaction per load/store, stalling upstream until ack or timeout.
// Optional MEM_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of aligning them down.
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 valid_EXMEM_in,
  input  logic                 memRead_EXMEM_in,
  input  logic                 memWrite_EXMEM_in,
  input  logic [2:0]           funct3_EXMEM_in,
  input  logic [31:0]          execute_rst_EXMEM_in,
  input  logic [31:0]          storeData_EXMEM_in,
  mem_access_stage_if.master   dmem,
  output logic                 stall_out,
  output logic [31:0]          memReadRst_MEMWB_in,
  output logic                 bus_err_out
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                 misaligned_out
`endif
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [0:0]    state;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    f3_q;
  logic [1:0]    lane_q;
  logic          load_q, squash_q;
  logic          access, mis, go, timeout, is_w, is_h;
  logic [31:0]   acc_wdata, ld_fmt;
  logic [3:0]    acc_be;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;

  assign access = valid_EXMEM_in & (memRead_EXMEM_in | memWrite_EXMEM_in) & ~flush;
  assign is_w   = funct3_EXMEM_in[1];
  assign is_h   = (funct3_EXMEM_in[1:0] == 2'b01);

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = access & ((is_h & execute_rst_EXMEM_in[0]) | (is_w & (|execute_rst_EXMEM_in[1:0])));
  assign misaligned_out = rst_n & (state == IDLE) & mis;
`else
  assign mis = 1'b0;
`endif

  assign go      = access & ~mis;
  // Ack in the final counted cycle wins over the timeout.
  assign timeout = (state == WAIT) & ~dmem.dmem_ack_in & (wait_cnt == CW'(ACK_TIMEOUT - 1));
  assign bus_err_out = timeout;
  assign stall_out   = rst_n & ((state == IDLE) ? go : (~dmem.dmem_ack_in & ~timeout));

  always_comb begin
    acc_wdata = storeData_EXMEM_in;
    acc_be    = 4'b1111;
    if (!is_w) begin
      if (is_h) begin
        acc_wdata = {2{storeData_EXMEM_in[15:0]}};
        acc_be    = execute_rst_EXMEM_in[1] ? 4'b1100 : 4'b0011;
      end else begin
        acc_wdata = {4{storeData_EXMEM_in[7:0]}};
        acc_be    = 4'b0001 << execute_rst_EXMEM_in[1:0];
      end
    end
  end

  always_comb begin
    rbyte = dmem.dmem_rdata_in[{lane_q, 3'b000} +: 8];
    rhalf = lane_q[1] ? dmem.dmem_rdata_in[31:16] : dmem.dmem_rdata_in[15:0];
    case (f3_q[1:0])
      2'b00:   ld_fmt = {{24{~f3_q[2] & rbyte[7]}}, rbyte};
      2'b01:   ld_fmt = {{16{~f3_q[2] & rhalf[15]}}, rhalf};
      default: ld_fmt = dmem.dmem_rdata_in;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      wait_cnt            <= '0;
      f3_q                <= '0;
      lane_q              <= '0;
      load_q              <= 1'b0;
      squash_q            <= 1'b0;
      dmem.dmem_req_out   <= 1'b0;
      dmem.dmem_we_out    <= 1'b0;
      dmem.dmem_addr_out  <= '0;
      dmem.dmem_wdata_out <= '0;
      dmem.dmem_be_out    <= '0;
      memReadRst_MEMWB_in <= '0;
    end else if (state == IDLE) begin
      if (go) begin
        state               <= WAIT;
        wait_cnt            <= '0;
        squash_q            <= 1'b0;
        f3_q                <= funct3_EXMEM_in;
        lane_q              <= execute_rst_EXMEM_in[1:0];
        load_q              <= ~memWrite_EXMEM_in;
        dmem.dmem_req_out   <= 1'b1;
        dmem.dmem_we_out    <= memWrite_EXMEM_in;
        dmem.dmem_addr_out  <= {execute_rst_EXMEM_in[31:2], 2'b00};
        dmem.dmem_wdata_out <= acc_wdata;
        dmem.dmem_be_out    <= acc_be;
      end
    end else begin
      // A squashed transaction still runs to completion on the bus; only the load result is dropped.
      if (flush) squash_q <= 1'b1;
      if (dmem.dmem_ack_in) begin
        state             <= IDLE;
        dmem.dmem_req_out <= 1'b0;
        dmem.dmem_we_out  <= 1'b0;
        if (load_q && !(squash_q || flush)) memReadRst_MEMWB_in <= ld_fmt;
      end else if (timeout) begin
        state             <= IDLE;
        dmem.dmem_req_out <= 1'b0;
        dmem.dmem_we_out  <= 1'b0;
        if (load_q && !(squash_q || flush)) memReadRst_MEMWB_in <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a spec-level reference model.
module tb_mem_access_stage;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        valid = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] ex_addr = '0, st_data = '0;
  logic        stall, bus_err;
  logic [31:0] result;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int total = 0, bad = 0;
  logic [31:0] exp_res = '0;

  mem_access_stage_if bus ();

  mem_access_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .valid_EXMEM_in(valid), .memRead_EXMEM_in(mem_rd), .memWrite_EXMEM_in(mem_wr),
    .funct3_EXMEM_in(funct3), .execute_rst_EXMEM_in(ex_addr), .storeData_EXMEM_in(st_data),
    .dmem(bus), .stall_out(stall), .memReadRst_MEMWB_in(result), .bus_err_out(bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misaligned_out(misaligned)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * lo)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * lo[1])) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic ref_access(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] wd, output logic [31:0] be);
    if (f3[1]) begin
      wd = d; be = 32'hF;
    end else if (f3[0]) begin
      wd = (d & 32'hFFFF) * 32'h0001_0001; be = 32'd3 << (2 * a[1]);
    end else begin
      wd = (d & 32'hFF) * 32'h0101_0101; be = 32'd1 << a[1:0];
    end
  endtask

  // ack_at: WAIT cycle (1-based) carrying ack, 0 = never. fl: 0 none, 1 flush in IDLE, 2 flush in first WAIT.
  task automatic run_txn(input bit ld, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                         input int ack_at, input logic [31:0] rd, input int fl);
    logic [31:0] e_wd, e_be;
    bit done;
    ref_access(f3, a, sd, e_wd, e_be);
    @(negedge clk);
    valid = 1'b1; mem_rd = ld; mem_wr = !ld; funct3 = f3; ex_addr = a; st_data = sd;
    flush = (fl == 1); bus.dmem_ack_in = 1'b0; bus.dmem_rdata_in = $urandom;
    #1;
    chk("idle_req", {31'b0, bus.dmem_req_out}, 32'd0);
    if (fl == 1) begin
      chk("flush_idle_stall", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      chk("flush_idle_noreq", {31'b0, bus.dmem_req_out}, 32'd0);
      valid = 1'b0; flush = 1'b0;
      return;
    end
    chk("idle_stall", {31'b0, stall}, 32'd1);
    done = 1'b0;
    for (int i = 1; i <= TO && !done; i++) begin
      @(negedge clk);
      flush = (fl == 2 && i == 1);
      bus.dmem_ack_in = (i == ack_at);
      bus.dmem_rdata_in = (i == ack_at) ? rd : $urandom;
      #1;
      chk("wait_req", {31'b0, bus.dmem_req_out}, 32'd1);
      chk("wait_we", {31'b0, bus.dmem_we_out}, {31'b0, !ld});
      chk("wait_addr", bus.dmem_addr_out, a & ~32'd3);
      chk("wait_be", {28'b0, bus.dmem_be_out}, e_be);
      if (!ld) chk("wait_wdata", bus.dmem_wdata_out, e_wd);
      chk("wait_stall", {31'b0, stall}, {31'b0, (i != ack_at) && (i != TO)});
      chk("wait_buserr", {31'b0, bus_err}, {31'b0, (i == TO) && (i != ack_at)});
      if (i == ack_at) begin
        if (ld && fl != 2) exp_res = ref_load(f3, a[1:0], rd);
        done = 1'b1;
      end else if (i == TO) begin
        if (ld && fl != 2) exp_res = 32'd0;
        done = 1'b1;
      end
    end
    @(negedge clk);
    valid = 1'b0; flush = 1'b0; bus.dmem_ack_in = 1'b0;
    #1;
    chk("done_req", {31'b0, bus.dmem_req_out}, 32'd0);
    chk("done_stall", {31'b0, stall}, 32'd0);
    chk("done_buserr", {31'b0, bus_err}, 32'd0);
    chk("result", result, exp_res);
  endtask

  initial begin
    bus.dmem_ack_in = 1'b0;
    bus.dmem_rdata_in = '0;
    // reset with a pending access: outputs all zero, no stall
    valid = 1'b1; mem_rd = 1'b1; funct3 = 3'd2;
    #12;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_req", {31'b0, bus.dmem_req_out}, 32'd0);
    chk("rst_we", {31'b0, bus.dmem_we_out}, 32'd0);
    chk("rst_addr", bus.dmem_addr_out, 32'd0);
    chk("rst_be", {28'b0, bus.dmem_be_out}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_buserr", {31'b0, bus_err}, 32'd0);
    valid = 1'b0; mem_rd = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // non-memory instruction: no stall, no request
    @(negedge clk);
    valid = 1'b1; #1;
    chk("nonmem_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("nonmem_req", {31'b0, bus.dmem_req_out}, 32'd0);
    valid = 1'b0;

    run_txn(1'b1, 3'd0, 32'h103, 32'h0, 1, 32'h80FF_FF12, 0);            // LB
    chk("lb_value", exp_res, 32'hFFFF_FF80);
    run_txn(1'b0, 3'd1, 32'h202, 32'h0000_ABCD, 2, 32'h0, 0);            // SH
    run_txn(1'b1, 3'd2, 32'h300, 32'h0, 3, 32'h1234_5678, 0);            // LW delayed ack
    run_txn(1'b1, 3'd2, 32'h304, 32'h0, 0, 32'h0, 0);                    // timeout
    chk("timeout_zero", result, 32'd0);
    run_txn(1'b1, 3'd5, 32'h306, 32'h0, TO, 32'hBEEF_0000, 0);           // ack wins at last cycle
    run_txn(1'b1, 3'd5, 32'h30A, 32'h0, 2, 32'h7777_8888, 2);            // LHU squashed
    run_txn(1'b0, 3'd0, 32'h400, 32'h55, 1, 32'h0, 1);                   // flush in IDLE
    run_txn(1'b1, 3'd2, 32'h001, 32'h0, 1, 32'hCAFE_F00D, 0);            // misaligned LW

    // ack while idle must not disturb anything
    @(negedge clk);
    bus.dmem_ack_in = 1'b1; bus.dmem_rdata_in = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.dmem_ack_in = 1'b0; #1;
    chk("idle_ack_result", result, exp_res);
    chk("idle_ack_req", {31'b0, bus.dmem_req_out}, 32'd0);

    // reset in the middle of WAIT abandons the access
    @(negedge clk);
    valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'd2; ex_addr = 32'h40;
    @(negedge clk); #1;
    chk("midrst_req_pre", {31'b0, bus.dmem_req_out}, 32'd1);
    rst_n = 1'b0; #1;
    exp_res = 32'd0;
    chk("midrst_req", {31'b0, bus.dmem_req_out}, 32'd0);
    chk("midrst_stall", {31'b0, stall}, 32'd0);
    chk("midrst_buserr", {31'b0, bus_err}, 32'd0);
    chk("midrst_result", result, exp_res);
    @(negedge clk);
    valid = 1'b0; rst_n = 1'b1;
    @(negedge clk); #1;
    chk("midrst_idle", {31'b0, bus.dmem_req_out}, 32'd0);

    for (int n = 0; n < 150; n++) begin
      bit ld;
      logic [2:0] f3;
      int ack_at, fl, sel;
      ld = $urandom_range(0, 1);
      sel = $urandom_range(0, 4);
      f3 = ld ? ((sel == 3) ? 3'd4 : (sel == 4) ? 3'd5 : 3'(sel)) : 3'($urandom_range(0, 2));
      ack_at = ($urandom_range(0, 39) == 0) ? 0 : $urandom_range(1, 6);
      fl = $urandom_range(0, 9);
      fl = (fl == 0) ? 1 : (fl == 1 && ack_at != 0) ? 2 : 0;
      run_txn(ld, f3, $urandom, $urandom, ack_at, $urandom, fl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 64, meaning the maximum number of WAIT cycles before a bus error is declared.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  squash current EX/MEM instruction.
- valid_EXMEM_in  in  1  EX/MEM slot holds a live instruction.
- memRead_EXMEM_in  in  1  load.
- memWrite_EXMEM_in  in  1  store.
- funct3_EXMEM_in  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- execute_rst_EXMEM_in  in  32  effective address.
- storeData_EXMEM_in  in  32  store source register.
- dmem_req_out  out  1  bus request.
- dmem_we_out  out  1  write strobe.
- dmem_addr_out  out  32  word-aligned address.
- dmem_wdata_out  out  32  lane-replicated store data.
- dmem_be_out  out  4  byte enables.
- dmem_ack_in  in  1  bus completion.
- dmem_rdata_in  in  32  read word, valid with ack.
- stall_out  out  1  hold upstream pipeline.
- memReadRst_MEMWB_in  out  32  formatted load result, feeds MEM/WB register.
- bus_err_out  out  1  one-cycle timeout pulse.
- misaligned_out  out  1  one-cycle pulse, present only with MEM_MISALIGN_TRAP_EN.

Function
REQ-003 SHALL implement FSM IDLE, WAIT; access = valid_EXMEM_in & (memRead|memWrite) & !flush.
REQ-004 In IDLE with access, SHALL assert stall_out combinationally, register dmem_req/we/addr/wdata/be, and enter WAIT next edge.
REQ-005 In IDLE without access, SHALL hold stall_out and dmem_req_out low.
REQ-006 In WAIT, SHALL hold dmem_req_out and all bus outputs stable until ack or timeout.
REQ-007 stall_out in WAIT SHALL equal !dmem_ack_in, so the pipeline advances on the ack edge.
REQ-008 On ack edge SHALL drop dmem_req_out, return to IDLE, and, for loads, register the formatted result into memReadRst_MEMWB_in; minimum access is 2 cycles (IDLE + WAIT with same-cycle ack).
REQ-009 Load formatting: lane = addr[1:0]; B sign-extends byte lane, BU zero-extends, H/HU select half addr[1] with sign/zero extension, W passes through.
REQ-010 Store formatting: B replicates byte to 4 lanes, be = 1<<addr[1:0]; H replicates half, be = 0011 or 1100 by addr[1]; W be = 1111.
REQ-011 dmem_addr_out SHALL be {addr[31:2],2'b00}.
REQ-012 memReadRst_MEMWB_in SHALL hold its value across stores, idle cycles and stalls.
REQ-013 flush in IDLE SHALL suppress the access (no request issued).
REQ-014 flush in WAIT SHALL mark the transaction squashed: request still held to ack (no bus abort), store commits at memory, load data discarded (result unchanged).
REQ-015 A WAIT cycle counter SHALL reset on WAIT entry. If ACK_TIMEOUT cycles pass without ack, the block SHALL drop req, pulse bus_err_out, zero the result for loads, deassert stall_out that cycle and return to IDLE.
REQ-016 Ack arriving in the timeout cycle SHALL win (normal completion, no bus_err).
REQ-017 Ack in IDLE SHALL be ignored.

Reset
REQ-018 rst_n low SHALL asynchronously force IDLE, counter 0 and every output 0; stall_out SHALL be 0 while in reset.
REQ-019 Reset mid-WAIT SHALL abandon the transaction with no result write and no bus_err.

Configuration
REQ-020 With MEM_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 SHALL issue no request, stay IDLE, pulse misaligned_out for one cycle, and not stall. Without it: misaligned_out is absent, low address bits beyond the access width are ignored, and the access proceeds aligned down.

Verification
REQ-021 LB addr 0x103, rdata 0x80FF_FF12, ack in first WAIT cycle -> be 1000, result 0xFFFF_FF80, stall high exactly 1 cycle.
REQ-022 SH addr 0x202, data 0x0000_ABCD -> wdata 0xABCD_ABCD, be 1100, we 1; result unchanged.
REQ-023 LW with ack delayed 3 WAIT cycles -> req stable for 3 cycles, stall deasserts on the ack cycle, result = rdata.
REQ-024 No ack for 64 cycles -> bus_err_out pulse at WAIT cycle 64, result 0, FSM IDLE; a second run with ack at cycle 64 -> no error.
REQ-025 flush in first WAIT cycle of LHU then ack -> result unchanged; flush with access in IDLE -> req never asserted.
REQ-026 With MEM_MISALIGN_TRAP_EN, LW addr 0x001 -> misaligned_out pulse, no req. Without it -> req to 0x000, be 1111.
